spi_crypto_bridge: RTL and testbench

SPI-slave command front end for the team's block-cipher cores, replacing the single fixed shift-register/START-pin arrangement with a command-framed protocol. Over one SPI frame the host writes a key, writes a text block, starts encryption or decryption, polls status, or reads back the result; the bridge holds all operands and drives the core's load/key/data/dec inputs. Data and key widths are parameters, so the same bridge serves AES-128/256 and narrower test cores.

---
 rtl/spi_crypto_bridge_if.sv | 9 +
 rtl/spi_crypto_bridge.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_crypto_bridge.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_crypto_bridge_if.sv
// SPI pin bundle between a host (master) and the crypto bridge (slave).
interface spi_crypto_bridge_if;
    logic CS_N;
    logic MOSI;
    logic MISO;

    modport master (output CS_N, output MOSI, input MISO);
    modport slave  (input CS_N, input MOSI, output MISO);
endinterface

// File: rtl/spi_crypto_bridge.sv
// SPI-slave command bridge holding key/text operands and the result for a block-cipher core.
// Define SPI_CRYPTO_KEY_READBACK_EN to add command 0x07 (READ_KEY).
module spi_crypto_bridge #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned KEY_W  = 256
) (
    input  logic               SCK,
    input  logic               RST_N,
    spi_crypto_bridge_if.slave spi,
    output logic               core_load_o,
    output logic               core_dec_o,
    output logic [KEY_W-1:0]   core_key_o,
    output logic [DATA_W-1:0]  core_data_o,
    input  logic [DATA_W-1:0]  core_data_i,
    input  logic               core_busy_i,
    output logic               BUSY,
    output logic               DONE
);

    localparam int unsigned SR_W  = (KEY_W > DATA_W) ? KEY_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(SR_W) + 1;

    localparam logic [CNT_W-1:0] LastKey  = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] LastData = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LastStat = CNT_W'(7);
    localparam logic [CNT_W-1:0] LastCmd  = CNT_W'(6);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrKey,
        StWrText,
        StRdResult,
        StRdStatus,
        StDiscard
`ifdef SPI_CRYPTO_KEY_READBACK_EN
        , StRdKey
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [6:0]          cmd_q, cmd_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [DATA_W-1:0]   text_q, text_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                dec_q, dec_d;
    logic                load_q, load_d;
    logic                miso_q, miso_d;
    logic                busy_q;

    logic [7:0]          cmd_byte;
    logic [7:0]          status;
    logic [SR_W-1:0]     rd_load;
    logic                rd_start;
    logic                capture;
    logic                err_set, err_clr, done_clr;

    assign cmd_byte = {cmd_q, spi.MOSI};
    assign status   = {5'b0, err_q, done_q, core_busy_i};
    // Result is captured on the falling edge of the core's busy flag.
    assign capture  = busy_q & ~core_busy_i;

    always_ff @(posedge SCK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        cmd_d    = cmd_q;
        sr_d     = sr_q;
        key_d    = key_q;
        text_d   = text_q;
        dec_d    = dec_q;
        load_d   = 1'b0;
        miso_d   = 1'b0;
        rd_load  = '0;
        rd_start = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        done_clr = 1'b0;

        if (spi.CS_N) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cmd_d   = {6'b0, spi.MOSI};
                    cnt_d   = '0;
                    state_d = StCmd;
                end
                StCmd: begin
                    cmd_d = {cmd_q[5:0], spi.MOSI};
                    if (cnt_q == LastCmd) begin
                        cnt_d   = '0;
                        state_d = StDiscard;
                        case (cmd_byte)
                            8'h01: state_d = StWrKey;
                            8'h02: state_d = StWrText;
                            8'h03, 8'h04: begin
                                if (!core_busy_i) begin
                                    dec_d    = cmd_byte[2];
                                    load_d   = 1'b1;
                                    done_clr = 1'b1;
                                end else begin
                                    err_set = 1'b1;
                                end
                            end
                            8'h05: begin
                                state_d  = StRdResult;
                                rd_load  = SR_W'(result_q) << (SR_W - DATA_W);
                                rd_start = 1'b1;
                                err_set  = ~done_q;
                            end
                            8'h06: begin
                                state_d  = StRdStatus;
                                rd_load  = SR_W'(status) << (SR_W - 8);
                                rd_start = 1'b1;
                            end
`ifdef SPI_CRYPTO_KEY_READBACK_EN
                            8'h07: begin
                                state_d  = StRdKey;
                                rd_load  = SR_W'(key_q) << (SR_W - KEY_W);
                                rd_start = 1'b1;
                            end
`endif
                            default: err_set = 1'b1;
                        endcase
                    end
                end
                StWrKey: begin
                    sr_d = {sr_q[SR_W-2:0], spi.MOSI};
                    if (cnt_q == LastKey) begin
                        key_d   = {sr_q[KEY_W-2:0], spi.MOSI};
                        state_d = StDiscard;
                    end
                end
                StWrText: begin
                    sr_d = {sr_q[SR_W-2:0], spi.MOSI};
                    if (cnt_q == LastData) begin
                        text_d  = {sr_q[DATA_W-2:0], spi.MOSI};
                        state_d = StDiscard;
                    end
                end
                StRdResult: begin
                    miso_d = sr_q[SR_W-1];
                    sr_d   = sr_q << 1;
                    if (cnt_q == LastData) begin
                        miso_d   = 1'b0;
                        done_clr = 1'b1;
                        state_d  = StDiscard;
                    end
                end
                StRdStatus: begin
                    miso_d = sr_q[SR_W-1];
                    sr_d   = sr_q << 1;
                    if (cnt_q == LastStat) begin
                        miso_d  = 1'b0;
                        err_clr = 1'b1;
                        state_d = StDiscard;
                    end
                end
`ifdef SPI_CRYPTO_KEY_READBACK_EN
                StRdKey: begin
                    miso_d = sr_q[SR_W-1];
                    sr_d   = sr_q << 1;
                    if (cnt_q == LastKey) begin
                        miso_d  = 1'b0;
                        state_d = StDiscard;
                    end
                end
`endif
                StDiscard: cnt_d = cnt_q;
                default:   state_d = StIdle;
            endcase
        end

        // First read bit leaves on the same edge that samples the last command bit.
        if (rd_start) begin
            miso_d = rd_load[SR_W-1];
            sr_d   = rd_load << 1;
        end
    end

    // Capture beats a same-edge DONE clear; an ERR set beats a same-edge clear.
    assign result_d = capture ? core_data_i : result_q;
    assign done_d   = capture ? 1'b1 : (done_clr ? 1'b0 : done_q);
    assign err_d    = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge SCK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            cmd_q    <= '0;
            sr_q     <= '0;
            key_q    <= '0;
            text_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dec_q    <= 1'b0;
            load_q   <= 1'b0;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            sr_q     <= sr_d;
            key_q    <= key_d;
            text_q   <= text_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dec_q    <= dec_d;
            load_q   <= load_d;
            miso_q   <= miso_d;
            busy_q   <= core_busy_i;
        end
    end

    assign spi.MISO    = miso_q;
    assign core_load_o = load_q;
    assign core_dec_o  = dec_q;
    assign core_key_o  = key_q;
    assign core_data_o = text_q;
    assign BUSY        = core_busy_i;
    assign DONE        = done_q;

endmodule

// File: tb/tb_spi_crypto_bridge.sv
// Scoreboard bench for spi_crypto_bridge: frames push expected MISO streams, a monitor compares.
// A mock cipher core returns the FIPS-197 AES-128 answer for the known key/plaintext pair.
module tb_spi_crypto_bridge;

    localparam int DW = 128;
    localparam int KW = 256;
    localparam int CoreLat = 100;

    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KF = {K, 128'h0};
    localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] A5 = {16{8'ha5}};

    logic          SCK = 1'b0;
    logic          RST_N = 1'b0;
    logic          core_load_o, core_dec_o, BUSY, DONE;
    logic [KW-1:0] core_key_o;
    logic [DW-1:0] core_data_o;
    logic [DW-1:0] core_data_i;
    logic          core_busy_i;

    spi_crypto_bridge_if spi_bus ();

    spi_crypto_bridge #(.DATA_W(DW), .KEY_W(KW)) dut (
        .SCK         (SCK),
        .RST_N       (RST_N),
        .spi         (spi_bus),
        .core_load_o (core_load_o),
        .core_dec_o  (core_dec_o),
        .core_key_o  (core_key_o),
        .core_data_o (core_data_o),
        .core_data_i (core_data_i),
        .core_busy_i (core_busy_i),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    always #5 SCK = ~SCK;

    function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] d,
                                            input logic dec);
        if (k == KF && !dec && d == P) return C;
        if (k == KF && dec && d == C) return P;
        return d ^ k[255:128];
    endfunction

    // Mock core: busy for CoreLat cycles after a load pulse, result valid as busy drops.
    int            lat_cnt;
    logic          busy_m;
    logic [DW-1:0] res_m;
    always @(posedge SCK or negedge RST_N) begin
        if (!RST_N) begin
            busy_m  <= 1'b0;
            lat_cnt <= 0;
            res_m   <= '0;
        end else if (core_load_o) begin
            busy_m  <= 1'b1;
            lat_cnt <= CoreLat;
        end else if (busy_m) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                busy_m <= 1'b0;
                res_m  <= cipher(core_key_o, core_data_o, core_dec_o);
            end
        end
    end
    assign core_busy_i = busy_m;
    assign core_data_i = res_m;

    int load_cnt = 0;
    always @(posedge SCK) if (core_load_o === 1'b1) load_cnt <= load_cnt + 1;

    typedef struct {
        string        name;
        int           w;
        logic [255:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Monitor: collects the MISO stream of each frame and checks it against the queue head.
    initial begin
        logic [511:0] smp;
        int           n;
        bit           in_f;
        exp_t         e;
        logic         bad;
        logic         eb;
        logic [255:0] got;
        n = 0;
        in_f = 0;
        smp = '0;
        forever begin
            @(posedge SCK);
            if (spi_bus.CS_N === 1'b0) begin
                #1;
                if (n < 512) smp[n] = spi_bus.MISO;
                n++;
                in_f = 1;
            end else if (in_f) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_unexpected: got frame of %0d bits want none", n);
                end else begin
                    e = sbq.pop_front();
                    bad = 0;
                    got = '0;
                    for (int p = 0; p < n && p < 512; p++) begin
                        eb = 1'b0;
                        if (p >= 7 && p < 7 + e.w) begin
                            eb  = e.v[e.w - 1 - (p - 7)];
                            got = {got[254:0], smp[p]};
                        end
                        if (smp[p] !== eb) bad = 1;
                    end
                    if (bad) begin
                        n_bad++;
                        $display("FAIL %s: miso got %h want %h", e.name, got, e.v);
                    end
                end
                in_f = 0;
                n = 0;
            end
        end
    end

    // Drives one frame; payload is left-aligned; rst_at >= 0 resets the DUT at that bit.
    task automatic frame(input string name, input logic [7:0] cmd, input logic [255:0] pay,
                         input int np, input int ew, input logic [255:0] ev, input int rst_at);
        exp_t e;
        e.name = name;
        e.w = ew;
        e.v = ev;
        sbq.push_back(e);
        for (int i = 0; i < 8 + np; i++) begin
            @(negedge SCK);
            if (i == rst_at) begin
                RST_N = 1'b0;
                spi_bus.CS_N = 1'b1;
                spi_bus.MOSI = 1'b0;
                #1;
                return;
            end
            spi_bus.CS_N = 1'b0;
            if (i < 8) spi_bus.MOSI = cmd[7-i];
            else spi_bus.MOSI = pay[255-(i-8)];
        end
        @(negedge SCK);
        spi_bus.CS_N = 1'b1;
        spi_bus.MOSI = 1'b0;
        repeat (2) @(negedge SCK);
    endtask

    task automatic status(input string name, input logic [7:0] exp);
        frame(name, 8'h06, '0, 8, 8, {248'h0, exp}, -1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (BUSY !== 1'b0 && k < 4 * CoreLat) begin
            @(negedge SCK);
            k++;
        end
        chk(name, {255'h0, BUSY}, 256'h0);
        repeat (3) @(negedge SCK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int ld0;
        spi_bus.CS_N = 1'b1;
        spi_bus.MOSI = 1'b0;
        repeat (3) @(negedge SCK);
        chk("rst_miso", {255'h0, spi_bus.MISO}, 256'h0);
        chk("rst_load_dec", {254'h0, core_load_o, core_dec_o}, 256'h0);
        chk("rst_key", core_key_o, 256'h0);
        chk("rst_data", {128'h0, core_data_o}, 256'h0);
        chk("rst_done", {255'h0, DONE}, 256'h0);
        RST_N = 1'b1;
        repeat (2) @(negedge SCK);

        status("status_after_reset", 8'h00);

        // AES-128 known-answer flow.
        frame("wr_key", 8'h01, KF, 256, 0, '0, -1);
        chk("key_commit", core_key_o, KF);
        frame("wr_text", 8'h02, {P, 128'h0}, 128, 0, '0, -1);
        chk("text_commit", {128'h0, core_data_o}, {128'h0, P});
        ld0 = load_cnt;
        frame("start_enc", 8'h03, '0, 0, 0, '0, -1);
        chk("enc_load_once", 256'(load_cnt), 256'(ld0 + 1));
        chk("enc_dec_flag", {255'h0, core_dec_o}, 256'h0);
        wait_idle("enc_busy_timeout");
        chk("enc_done_set", {255'h0, DONE}, 256'h1);
        status("status_done", 8'h02);
        frame("rd_aes", 8'h05, '0, 128, 128, {128'h0, C}, -1);
        chk("done_cleared_by_read", {255'h0, DONE}, 256'h0);

        // Aborted write keeps the old text; a full write commits exactly.
        frame("wr_abort", 8'h02, {{16{8'h5a}}, 128'h0}, 40, 0, '0, -1);
        chk("abort_keeps_text", {128'h0, core_data_o}, {128'h0, P});
        frame("wr_a5", 8'h02, {A5, 128'h0}, 128, 0, '0, -1);
        chk("a5_commit", {128'h0, core_data_o}, {128'h0, A5});

        // Start while busy is rejected and flags ERR.
        ld0 = load_cnt;
        frame("start_a5", 8'h03, '0, 0, 0, '0, -1);
        frame("start_busy", 8'h03, '0, 0, 0, '0, -1);
        chk("busy_start_no_load", 256'(load_cnt), 256'(ld0 + 1));
        status("status_err_busy", 8'h05);
        status("status_err_cleared", 8'h01);
        wait_idle("a5_busy_timeout");
        status("status_a5_done", 8'h02);
        frame("rd_a5", 8'h05, '0, 128, 128, {128'h0, A5 ^ K}, -1);
        frame("rd_stale", 8'h05, '0, 128, 128, {128'h0, A5 ^ K}, -1);
        status("status_stale_err", 8'h04);

        // Unknown command: silent MISO, ERR set.
        frame("unknown_ff", 8'hff, '0, 16, 0, '0, -1);
        status("status_unknown", 8'h04);
`ifdef SPI_CRYPTO_KEY_READBACK_EN
        frame("rd_key", 8'h07, '0, 256, 256, KF, -1);
        status("status_rd_key", 8'h00);
`else
        frame("cmd07_unknown", 8'h07, '0, 16, 0, '0, -1);
        status("status_cmd07", 8'h04);
`endif

        // Decrypt path.
        frame("wr_ct", 8'h02, {C, 128'h0}, 128, 0, '0, -1);
        ld0 = load_cnt;
        frame("start_dec", 8'h04, '0, 0, 0, '0, -1);
        chk("dec_load_once", 256'(load_cnt), 256'(ld0 + 1));
        chk("dec_flag", {255'h0, core_dec_o}, 256'h1);
        wait_idle("dec_busy_timeout");
        frame("rd_dec", 8'h05, '0, 128, 128, {128'h0, P}, -1);

        // Reset in the middle of a read.
        frame("rd_reset", 8'h05, '0, 128, 128, {128'h0, P}, 48);
        chk("midrst_miso", {255'h0, spi_bus.MISO}, 256'h0);
        chk("midrst_load_dec", {254'h0, core_load_o, core_dec_o}, 256'h0);
        chk("midrst_key", core_key_o, 256'h0);
        chk("midrst_data", {128'h0, core_data_o}, 256'h0);
        chk("midrst_done", {255'h0, DONE}, 256'h0);
        @(negedge SCK);
        RST_N = 1'b1;
        repeat (2) @(negedge SCK);
        status("status_after_midrst", 8'h00);

        repeat (4) @(negedge SCK);
        chk("scoreboard_drained", 256'(sbq.size()), 256'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
